// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 types and timing defaults for host transmitter and
//               keyboard receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam int unsigned c_DEF_INHIBIT_CYC = 5000;    // 100 us at 50 MHz
    localparam int unsigned c_DEF_TIMEOUT_CYC = 750000;  // 15 ms at 50 MHz

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_REQ      = 3'd2,
        ST_BITS     = 3'd3,
        ST_ACK      = 3'd4,
        ST_WAIT_REL = 3'd5,
        ST_FIN      = 3'd6
    } ps2_tx_state_e;

    function automatic logic ps2_odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Counter width covering the longer of the two timing intervals.
    function automatic int unsigned ps2_cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? int'($clog2(m)) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx_if
// Description : Command handshake and raw PS/2 line bundle for ps2_host_tx.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic       ps2_clk_i;
    logic       ps2_dat_i;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    modport master (
        output tx_data, start, ps2_clk_i, ps2_dat_i,
        input  busy, done, err, ps2_clk_oe, ps2_dat_oe
    );

    modport slave (
        input  tx_data, start, ps2_clk_i, ps2_dat_i,
        output busy, done, err, ps2_clk_oe, ps2_dat_oe
    );

endinterface
`default_nettype wire

// File: rtl/ps2_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_sync
// Description : Two-flop synchronizer with falling-edge detect for one PS/2 line.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_fe
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = i_line;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign o_level = sync_q;
    assign o_fe    = prev_q & ~sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device command transmitter (open-drain enables).
//               Define PS2_TX_ACK_CHECK_EN to sample the device acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = c_DEF_INHIBIT_CYC,
    parameter int unsigned TIMEOUT_CYC = c_DEF_TIMEOUT_CYC
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus
);

    localparam int unsigned c_cnt_w = ps2_cnt_width(INHIBIT_CYC, TIMEOUT_CYC);
    localparam logic [c_cnt_w-1:0] c_inh_last = c_cnt_w'(INHIBIT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

`ifdef PS2_TX_ACK_CHECK_EN
    localparam ps2_tx_state_e c_after_stop = ST_ACK;
`else
    localparam ps2_tx_state_e c_after_stop = ST_WAIT_REL;
`endif

    ps2_tx_state_e      state_q, state_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic [7:0]         data_q, data_d;
    logic               par_q, par_d;
    logic               drv_q, drv_d;
    logic               err_q, err_d;

    logic w_clk_lvl, w_clk_fe;
    logic w_dat_lvl, w_dat_fe_unused;
    logic w_clk_oe, w_dat_oe, w_busy, w_done, w_tmo;

    ps2_sync u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .i_line  (bus.ps2_clk_i),
        .o_level (w_clk_lvl),
        .o_fe    (w_clk_fe)
    );

    ps2_sync u_sync_dat (
        .clk     (clk),
        .rst     (rst),
        .i_line  (bus.ps2_dat_i),
        .o_level (w_dat_lvl),
        .o_fe    (w_dat_fe_unused)
    );

    assign w_tmo = (cnt_q == c_tmo_last);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        par_d    = par_q;
        drv_d    = drv_q;
        err_d    = err_q;
        w_clk_oe = 1'b0;
        w_dat_oe = 1'b0;
        w_busy   = 1'b1;
        w_done   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    data_d  = bus.tx_data;
                    par_d   = ps2_odd_parity(bus.tx_data);
                    cnt_d   = '0;
                    bit_d   = '0;
                    drv_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                w_clk_oe = 1'b1;
                if (cnt_q == c_inh_last) begin
                    w_dat_oe = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_REQ;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            // Clock released with data low: the start bit stays driven in BITS
            // until the device's first falling edge.
            ST_REQ: begin
                w_dat_oe = 1'b1;
                drv_d    = 1'b1;
                cnt_d    = cnt_q + c_cnt_one;
                state_d  = ST_BITS;
            end

            ST_BITS: begin
                w_dat_oe = drv_q;
                if (w_clk_fe) begin
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q < 4'd8) begin
                        drv_d = ~data_q[bit_q[2:0]];
                    end else if (bit_q == 4'd8) begin
                        drv_d = ~par_q;
                    end else begin
                        drv_d   = 1'b0;
                        state_d = c_after_stop;
                    end
                end else if (w_tmo) begin
                    drv_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            ST_ACK: begin
                if (w_clk_fe) begin
                    cnt_d   = '0;
                    err_d   = w_dat_lvl;
                    state_d = ST_WAIT_REL;
                end else if (w_tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            ST_WAIT_REL: begin
                if (w_clk_lvl && w_dat_lvl) begin
                    cnt_d   = '0;
                    state_d = ST_FIN;
                end else if (w_tmo) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end

            ST_FIN: begin
                w_busy  = 1'b0;
                w_done  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                w_busy  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            drv_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            par_q   <= par_d;
            drv_q   <= drv_d;
            err_q   <= err_d;
        end
    end

    // Line enables decode straight from registered state so reset releases
    // both lines in the same cycle it is asserted.
    assign bus.ps2_clk_oe = w_clk_oe;
    assign bus.ps2_dat_oe = w_dat_oe;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a PS/2 device model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int unsigned c_INH  = 20;
    localparam int unsigned c_TMO  = 400;
    localparam int          c_HALF = 8;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam logic c_ACK_CHECKED = 1'b1;
`else
    localparam logic c_ACK_CHECKED = 1'b0;
`endif

    logic clk;
    logic rst;
    logic dev_clk_low;
    logic dev_dat_low;
    logic line_clk;
    logic line_dat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    assign line_clk      = ~(bus.ps2_clk_oe | dev_clk_low);
    assign line_dat      = ~(bus.ps2_dat_oe | dev_dat_low);
    assign bus.ps2_clk_i = line_clk;
    assign bus.ps2_dat_i = line_dat;

    ps2_host_tx #(
        .INHIBIT_CYC (c_INH),
        .TIMEOUT_CYC (c_TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       err;
        logic       chk;
        logic [9:0] frame;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] cap_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         done_seen   = 0;
    int         accepted    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference frame as the device sees it: data LSB first, odd parity, stop.
    function automatic logic [9:0] ref_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    task automatic issue(input logic [7:0] d, input logic exp_err, input logic chk);
        exp_t e;
        e.err   = exp_err;
        e.chk   = chk;
        e.frame = ref_frame(d);
        exp_q.push_back(e);
        bus.tx_data = d;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.tx_data = 8'($urandom);
        check("accept_busy", 32'(bus.busy), 32'd1);
    endtask

    // Device side: waits for the request, clocks 11 bits, samples on rising edges.
    task automatic dev_xfer(input logic ack, input int abort_at);
        int         waited;
        logic       seen;
        logic [9:0] f;
        waited = 0;
        f      = '0;
        seen   = (bus.ps2_clk_oe == 1'b0) && (bus.ps2_dat_oe == 1'b1);
        while (!seen && waited < int'(c_INH) + 50) begin
            @(negedge clk);
            waited++;
            seen = (bus.ps2_clk_oe == 1'b0) && (bus.ps2_dat_oe == 1'b1);
        end
        check("req_seen", 32'(seen), 32'd1);
        if (!seen) return;
        repeat (c_HALF) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            dev_clk_low = 1'b1;
            repeat (c_HALF) @(negedge clk);
            if (i == abort_at) return;
            dev_clk_low = 1'b0;
            if (i <= 10) f[i-1] = line_dat;
            if (i == 10) begin
                cap_q.push_back(f);
                dev_dat_low = ack;
            end
            repeat (c_HALF) @(negedge clk);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int elapsed;
        elapsed = 0;
        while (done_seen < target && elapsed < budget) begin
            @(negedge clk);
            elapsed++;
        end
        check("done_count", 32'(done_seen), 32'(target));
        repeat (3) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [9:0] f;
        forever begin
            @(negedge clk);
            if (!rst && bus.done) begin
                done_seen++;
                check("expect_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("err", 32'(bus.err), 32'(e.err));
                    check("done_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
                    check("done_dat_oe", 32'(bus.ps2_dat_oe), 32'd0);
                    check("done_busy", 32'(bus.busy), 32'd0);
                    if (e.chk) begin
                        check("frame_ready", 32'(cap_q.size() != 0), 32'd1);
                        if (cap_q.size() != 0) begin
                            f = cap_q.pop_front();
                            check("frame", 32'(f), 32'(e.frame));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d dones, expected %0d", done_seen, accepted);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] d;
        logic       a;
        int         elapsed;
        logic [7:0] dir_vals [3];
        dir_vals[0] = 8'h00;
        dir_vals[1] = 8'hFF;
        dir_vals[2] = 8'h01;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(bus.ps2_dat_oe), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
        check("post_rst_dat_oe", 32'(bus.ps2_dat_oe), 32'd0);

        // 0xED with start pokes while busy (INHIBIT and BITS)
        issue(8'hED, 1'b0, 1'b1);
        accepted++;
        fork
            dev_xfer(1'b1, 0);
            begin
                repeat (5) @(negedge clk);
                bus.start = 1'b1; bus.tx_data = 8'h3C;
                @(negedge clk);
                bus.start = 1'b0;
                repeat (int'(c_INH) + 40) @(negedge clk);
                bus.start = 1'b1; bus.tx_data = 8'hC5;
                @(negedge clk);
                bus.start = 1'b0;
            end
        join
        wait_done(accepted, 300);

        for (int k = 0; k < 3; k++) begin
            issue(dir_vals[k], 1'b0, 1'b1);
            accepted++;
            dev_xfer(1'b1, 0);
            wait_done(accepted, 300);
        end

        // Device leaves data high in the acknowledge slot
        issue(8'h5A, c_ACK_CHECKED, 1'b1);
        accepted++;
        dev_xfer(1'b0, 0);
        wait_done(accepted, 300);

        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            a = ($urandom_range(0, 3) != 0);
            issue(d, a ? 1'b0 : c_ACK_CHECKED, 1'b1);
            accepted++;
            dev_xfer(a, 0);
            wait_done(accepted, 300);
        end

        // Device never clocks; start pulsed during the done cycle
        issue(8'hC3, 1'b1, 1'b0);
        accepted++;
        elapsed = 0;
        while (!bus.done && elapsed < int'(c_INH + c_TMO) + 50) begin
            @(negedge clk);
            elapsed++;
        end
        check("timeout_done", 32'(bus.done), 32'd1);
        check("timeout_latency", 32'(elapsed >= int'(c_INH + c_TMO) - 2 && elapsed <= int'(c_INH + c_TMO) + 2), 32'd1);
        bus.start = 1'b1; bus.tx_data = 8'h99;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("fin_start_ignored", 32'(bus.busy), 32'd0);
        wait_done(accepted, 10);

        // Reset after the fourth device falling edge of 0xA5
        issue(8'hA5, 1'b0, 1'b1);
        dev_xfer(1'b1, 4);
        check("mid_busy", 32'(bus.busy), 32'd1);
        check("mid_dat_oe", 32'(bus.ps2_dat_oe), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
        check("async_rst_dat_oe", 32'(bus.ps2_dat_oe), 32'd0);
        exp_q.delete();
        cap_q.delete();
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort_err", 32'(bus.err), 32'd0);
        issue(8'h55, 1'b0, 1'b1);
        accepted++;
        dev_xfer(1'b1, 0);
        wait_done(accepted, 300);

        repeat (20) @(negedge clk);
        check("all_expects_consumed", 32'(exp_q.size()), 32'd0);
        check("total_dones", 32'(done_seen), 32'(accepted));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
